// File: rtl/wave_counter_nbit_if.sv
// wave_counter_nbit_if
//    Control/status bundle for the N-bit waveform counter.
//    master : drives enable/mode/limit/load/load_value, observes q/dir/tc
//    slave  : the counter side (inverse directions)
//    WIDTH  : counter width, must match the counter instance
interface wave_counter_nbit_if #(
   parameter int WIDTH = 3
);
   logic             enable;
   logic [1:0]       mode;
   logic [WIDTH-1:0] limit;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] q;
   logic             dir;
   logic             tc;

   modport master (
      output enable, mode, limit, load, load_value,
      input  q, dir, tc
   );

   modport slave (
      input  enable, mode, limit, load, load_value,
      output q, dir, tc
   );
endinterface

// File: rtl/wave_counter_nbit.sv
// wave_counter_nbit
//    Parametrised N-bit waveform counter: up-sawtooth, down-sawtooth,
//    triangle and hold modes over the range 0..limit, with parallel load
//    and a registered terminal-count pulse.
//    clock : rising-edge clock
//    clear : synchronous active-high reset (q=0, dir=up, tc=0)
//    bus   : slave modport carrying enable, mode, limit, load, load_value
//            in and q, dir, tc out; all outputs come straight from flops.
module wave_counter_nbit #(
   parameter int WIDTH = 3
) (
   input logic                clock,
   input logic                clear,
   wave_counter_nbit_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_TRI  = 2'b10,
      MODE_HOLD = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   logic [WIDTH-1:0] q_r, q_nxt;
   dir_t             dir_r, dir_nxt;
   logic             tc_r, tc_nxt;

   mode_t            mode;
   logic             step_en;
   logic             lim_zero;
   logic             at_top;      // q at or above limit
   logic             above_lim;   // q strictly above limit
   logic             at_zero;
   logic [WIDTH-1:0] q_inc, q_dec, lim_dec;

   assign mode      = mode_t'(bus.mode);
   assign step_en   = bus.enable && (mode != MODE_HOLD);
   assign lim_zero  = (bus.limit == '0);
   assign at_top    = (q_r >= bus.limit);
   assign above_lim = (q_r > bus.limit);
   assign at_zero   = (q_r == '0);
   // Increment only used when q < limit and decrement only when q > 0,
   // so neither can wrap.
   assign q_inc     = q_r + WIDTH'(1);
   assign q_dec     = q_r - WIDTH'(1);
   assign lim_dec   = bus.limit - WIDTH'(1);

   always_ff @(posedge clock) begin
      if (clear) begin
         q_r   <= '0;
         dir_r <= DIR_UP;
         tc_r  <= 1'b0;
      end else begin
         q_r   <= q_nxt;
         dir_r <= dir_nxt;
         tc_r  <= tc_nxt;
      end
   end

   always_comb begin
      q_nxt   = q_r;
      dir_nxt = dir_r;
      tc_nxt  = 1'b0;

      if (bus.load) begin
         q_nxt = bus.load_value;
      end else if (step_en) begin
         if (lim_zero) begin
            // Degenerate range: every enabled step is a wrap back to 0.
            q_nxt  = '0;
            tc_nxt = 1'b1;
            unique case (mode)
               MODE_UP:   dir_nxt = DIR_UP;
               MODE_DOWN: dir_nxt = DIR_DOWN;
               MODE_TRI:  dir_nxt = (dir_r == DIR_UP) ? DIR_DOWN : DIR_UP;
               default:   dir_nxt = dir_r;
            endcase
         end else begin
            unique case (mode)
               MODE_UP: begin
                  dir_nxt = DIR_UP;
                  if (at_top) begin
                     q_nxt  = '0;
                     tc_nxt = 1'b1;
                  end else begin
                     q_nxt = q_inc;
                  end
               end

               MODE_DOWN: begin
                  dir_nxt = DIR_DOWN;
                  if (at_zero || above_lim) begin
                     q_nxt  = bus.limit;
                     tc_nxt = 1'b1;
                  end else begin
                     q_nxt = q_dec;
                  end
               end

               MODE_TRI: begin
                  // Turns skip the endpoint so it is never shown twice.
                  if (dir_r == DIR_UP) begin
                     if (at_top) begin
                        q_nxt   = lim_dec;
                        dir_nxt = DIR_DOWN;
                        tc_nxt  = 1'b1;
                     end else begin
                        q_nxt = q_inc;
                     end
                  end else begin
                     if (at_zero) begin
                        q_nxt   = WIDTH'(1);
                        dir_nxt = DIR_UP;
                        tc_nxt  = 1'b1;
                     end else if (above_lim) begin
                        q_nxt  = bus.limit;
                        tc_nxt = 1'b1;
                     end else begin
                        q_nxt = q_dec;
                     end
                  end
               end

               default: ;
            endcase
         end
      end
   end

   assign bus.q   = q_r;
   assign bus.dir = dir_r;
   assign bus.tc  = tc_r;

endmodule
